// File: rtl/tc_pkg.sv
// tc_pkg: shared state encoding, default width and counter sizing for tc_deserializer
package tc_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int TC_WIDTH_DEFAULT = 8;

    function automatic int cnt_w(input int width);
        return width > 1 ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tc_serial_cell.sv
// tc_serial_cell: bit-serial two's-complement cell, pass bits up to the first one, invert after it
module tc_serial_cell (
    input  logic t_clock,
    input  logic r,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic y
);

    logic seen_one;

    assign y = d ^ (seen_one & ~clr);

    always_ff @(posedge t_clock) begin
        if (r)
            seen_one <= 1'b0;
        else if (en)
            seen_one <= (seen_one & ~clr) | d;
    end

endmodule

// File: rtl/tc_deserializer.sv
// tc_deserializer: frames an LSB-first serial stream into words, optionally re-negating each word
module tc_deserializer
    import tc_pkg::*;
#(
    parameter int WIDTH  = TC_WIDTH_DEFAULT,
    parameter bit NEGATE = 1'b1
) (
    input  logic             t_clock,
    input  logic             r,
    input  logic             i,
    input  logic             i_vld,
    input  logic             i_sof,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic             neg,
    output logic             err
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            done;
    logic            y;
    logic            b;
    logic [WIDTH-1:0] word;

    assign accept = i_vld & (i_sof | state == SHIFT);
    assign done   = accept & (i_sof ? WIDTH == 1 : cnt == LAST);
    assign b      = NEGATE ? y : i;

    tc_serial_cell u_cell (
        .t_clock (t_clock),
        .r       (r),
        .clr     (i_sof),
        .en      (accept),
        .d       (i),
        .y       (y)
    );

    // Only the newest WIDTH-1 bits are stored; the arriving bit completes the word.
    if (WIDTH == 1) begin : g_one
        assign word = b;
    end else begin : g_sr
        logic [WIDTH-2:0] sr;
        assign word = {b, sr};
        always_ff @(posedge t_clock) begin
            if (r)
                sr <= '0;
            else if (accept)
                sr <= word[WIDTH-1:1];
        end
    end

    always_ff @(posedge t_clock) begin
        if (r) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            neg   <= 1'b0;
            q_vld <= 1'b0;
            err   <= 1'b0;
        end else begin
            q_vld <= done;
            err   <= i_vld & i_sof & (state == SHIFT);
            if (done) begin
                q   <= word;
                neg <= i;
            end
            if (accept) begin
                state <= done ? IDLE : SHIFT;
                cnt   <= done ? '0 : i_sof ? CW'(1) : cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tc_deserializer.sv
// tb_tc_deserializer: randomized and directed checks of tc_deserializer against an arithmetic model
module tb_tc_deserializer;

    logic       t_clock = 1'b0;
    logic       r = 1'b1;
    logic       i_drv = 1'b0;
    logic       i_vld = 1'b0;
    logic       i_sof = 1'b0;
    logic       lb = 1'b0;
    logic       i;
    logic       tx_y;
    logic [7:0] q, q_raw;
    logic       q_vld, neg, err, q_vld_raw, neg_raw, err_raw;

    int errors = 0;
    int checks = 0;
    int cyc = 0, vld_cnt = 0, err_cnt = 0, both_cnt = 0, last_vld = 0, prev_vld = 0;
    int n;

    always #5 t_clock = ~t_clock;

    assign i = lb ? tx_y : i_drv;

    tc_serial_cell u_tx (.t_clock(t_clock), .r(r), .clr(i_sof), .en(i_vld), .d(i_drv), .y(tx_y));

    tc_deserializer #(.WIDTH(8), .NEGATE(1'b1)) dut (
        .t_clock(t_clock), .r(r), .i(i), .i_vld(i_vld), .i_sof(i_sof),
        .q(q), .q_vld(q_vld), .neg(neg), .err(err)
    );

    tc_deserializer #(.WIDTH(8), .NEGATE(1'b0)) dut_raw (
        .t_clock(t_clock), .r(r), .i(i), .i_vld(i_vld), .i_sof(i_sof),
        .q(q_raw), .q_vld(q_vld_raw), .neg(neg_raw), .err(err_raw)
    );

    // Outputs seen here are the ones held during the cycle that just ended.
    always @(posedge t_clock) begin
        cyc++;
        if (q_vld) begin
            vld_cnt++;
            prev_vld = last_vld;
            last_vld = cyc;
        end
        if (err) err_cnt++;
        if (q_vld && err) both_cnt++;
    end

    function automatic logic [7:0] tc(input logic [7:0] x);
        return 8'((9'd256 - {1'b0, x}) % 9'd256);
    endfunction

    task automatic drive(input logic v, input logic s, input logic d);
        i_vld = v;
        i_sof = s;
        i_drv = d;
        @(negedge t_clock);
    endtask

    task automatic idle(input int c);
        for (int k = 0; k < c; k++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] w, input int gap_at, input int gap_len, input int nbits, output int cycles);
        cycles = 0;
        for (int k = 0; k < nbits; k++) begin
            if (k == gap_at)
                for (int g = 0; g < gap_len; g++) begin
                    drive(1'b0, 1'b0, 1'b0);
                    cycles++;
                end
            drive(1'b1, k == 0, w[k]);
            cycles++;
        end
    endtask

    task automatic test_reset;
        r = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++; if ({q_vld, neg, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {q_vld, neg, err}); end
        r = 1'b0;
        idle(2);
    endtask

    task automatic test_basic;
        send(8'hFA, -1, 0, 8, n);
        checks++; if (q_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got=%b exp=1", q_vld); end
        checks++; if (q !== tc(8'hFA) || q !== 8'h06) begin errors++; $display("FAIL basic_q got=%h exp=06", q); end
        checks++; if (neg !== 1'b1) begin errors++; $display("FAIL basic_neg got=%b exp=1", neg); end
        idle(1);
        checks++; if (q_vld !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b exp=0", q_vld); end
        checks++; if (q !== 8'h06) begin errors++; $display("FAIL basic_hold got=%h exp=06", q); end
        idle(1);
    endtask

    task automatic test_back_to_back;
        send(8'h00, -1, 0, 8, n);
        checks++; if ({q_vld, neg, q} !== {2'b10, 8'h00}) begin errors++; $display("FAIL b2b_first got=%b%b_%h exp=10_00", q_vld, neg, q); end
        send(8'h80, -1, 0, 8, n);
        checks++; if ({q_vld, neg, q} !== {2'b11, 8'h80}) begin errors++; $display("FAIL b2b_second got=%b%b_%h exp=11_80", q_vld, neg, q); end
        idle(2);
        checks++; if (last_vld - prev_vld !== 8) begin errors++; $display("FAIL b2b_spacing got=%0d exp=8", last_vld - prev_vld); end
    endtask

    task automatic test_gap;
        int v0;
        v0 = vld_cnt;
        send(8'h01, 3, 3, 8, n);
        checks++; if (q_vld !== 1'b1 || n !== 11) begin errors++; $display("FAIL gap_latency got=vld%b/%0d exp=vld1/11", q_vld, n); end
        checks++; if ({neg, q} !== {1'b0, 8'hFF}) begin errors++; $display("FAIL gap_q got=%b_%h exp=0_ff", neg, q); end
        idle(2);
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL gap_pulses got=%0d exp=1", vld_cnt - v0); end
    endtask

    task automatic test_restart;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        send(8'h0B, -1, 0, 4, n);
        send(8'h05, -1, 0, 8, n);
        checks++; if ({q_vld, neg, q} !== {2'b10, 8'hFB}) begin errors++; $display("FAIL restart_q got=%b%b_%h exp=10_fb", q_vld, neg, q); end
        idle(2);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL restart_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL restart_vld got=%0d exp=1", vld_cnt - v0); end
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        send(8'h1F, -1, 0, 5, n);
        r = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        r = 1'b0;
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1);
        idle(2);
        checks++; if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL midreset_quiet got=vld%0d/err%0d exp=0/0", vld_cnt - v0, err_cnt - e0); end
        send(8'h03, -1, 0, 8, n);
        checks++; if ({q_vld, neg, q} !== {2'b10, 8'hFD}) begin errors++; $display("FAIL midreset_q got=%b%b_%h exp=10_fd", q_vld, neg, q); end
        idle(2);
        checks++; if (vld_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin errors++; $display("FAIL midreset_pulses got=vld%0d/err%0d exp=1/0", vld_cnt - v0, err_cnt - e0); end
    endtask

    task automatic test_random;
        logic [7:0] w;
        for (int k = 0; k < 40; k++) begin
            w = 8'($urandom);
            send(w, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 8, n);
            checks++; if ({q_vld, neg, q} !== {1'b1, w[7], tc(w)}) begin errors++; $display("FAIL random_q raw=%h got=%b%b_%h exp=1%b_%h", w, q_vld, neg, q, w[7], tc(w)); end
            checks++; if ({q_vld_raw, neg_raw, q_raw} !== {1'b1, w[7], w}) begin errors++; $display("FAIL random_raw raw=%h got=%b%b_%h", w, q_vld_raw, neg_raw, q_raw); end
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);
    endtask

    task automatic test_loopback(input bit raw_mode);
        logic [7:0] x, t;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        lb = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            x = 8'($urandom);
            t = tc(x);
            send(x, -1, 0, 8, n);
            if (raw_mode) begin
                checks++; if ({q_vld_raw, neg_raw, q_raw} !== {1'b1, t[7], t}) begin errors++; $display("FAIL loop_raw op=%h got=%b%b_%h exp=1%b_%h", x, q_vld_raw, neg_raw, q_raw, t[7], t); end
            end else begin
                checks++; if ({q_vld, neg, q} !== {1'b1, t[7], x}) begin errors++; $display("FAIL loop_neg op=%h got=%b%b_%h exp=1%b_%h", x, q_vld, neg, q, t[7], x); end
            end
        end
        idle(2);
        lb = 1'b0;
        checks++; if (vld_cnt - v0 !== 1000 || err_cnt - e0 !== 0) begin errors++; $display("FAIL loop_pulses got=vld%0d/err%0d exp=1000/0", vld_cnt - v0, err_cnt - e0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_gap;
        test_restart;
        test_reset_mid;
        test_random;
        test_loopback(1'b0);
        test_loopback(1'b1);
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL vld_err_overlap got=%0d exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
